// File: rtl/aes_top_pack.sv
// Shared transmit-stream constants and arbiter state type.
// Imported by the stream arbiter and its round-robin picker.
package aes_top_pack;

  localparam int AES_ST_DATA_WIDTH  = 32;
  localparam int AES_ST_EMPTY_WIDTH = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_e;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request
// scanning upward from last_grant+1, wrapping at NUM_PORTS.
module aes_rr_pick
  import aes_top_pack::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 pick_valid,
  output logic [IDX_W-1:0]     pick_idx
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      jj = IDX_W'(j);
      if (!pick_valid && req[jj]) begin
        pick_valid = 1'b1;
        pick_idx   = jj;
      end
    end
  end

endmodule

// File: rtl/aes_tx_stream_arbiter.sv
// Packet-level round-robin arbiter onto one registered Avalon-ST stream.
// Define AES_TX_ARB_STATS_EN to add per-port packet counters (pkt_count).
module aes_tx_stream_arbiter
  import aes_top_pack::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_WIDTH  = AES_ST_DATA_WIDTH,
  parameter int EMPTY_WIDTH = AES_ST_EMPTY_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS-1:0]             in_sop,
  input  logic [NUM_PORTS-1:0]             in_eop,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_PORTS-1:0]             in_ready,
  input  logic [NUM_PORTS-1:0]             cfg_port_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EMPTY_WIDTH-1:0]           out_empty,
  input  logic                             out_ready,
  output logic                             grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
  output logic                             orphan_err
`ifdef AES_TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          pkt_count
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e             state;
  logic [IDX_W-1:0]       last_grant;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   orphan;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   take;

  logic [DATA_WIDTH-1:0]  data_a  [NUM_PORTS];
  logic [EMPTY_WIDTH-1:0] empty_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  g_data;
  logic [EMPTY_WIDTH-1:0] g_empty;
  logic                   g_valid;
  logic                   g_sop;
  logic                   g_eop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
    assign data_a[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign empty_a[i] = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
  end

  assign g_data  = data_a[grant_idx];
  assign g_empty = empty_a[grant_idx];
  assign g_valid = in_valid[grant_idx];
  assign g_sop   = in_sop[grant_idx];
  assign g_eop   = in_eop[grant_idx];

  assign req    = in_valid & in_sop & cfg_port_en;
  assign orphan = in_valid & ~in_sop & cfg_port_en;

  aes_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  // In IDLE only orphan beats are drained; the granted
  // source sees ready only while the output slot frees up.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      unique case (state)
        ARB_IDLE: in_ready = orphan;
        ARB_XFER: in_ready[grant_idx] = out_ready | ~out_valid;
      endcase
    end
  end

  assign take = (state == ARB_XFER) && g_valid && in_ready[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      last_grant  <= IDX_W'(NUM_PORTS - 1);
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      orphan_err  <= 1'b0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_data    <= '0;
      out_empty   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|orphan) orphan_err <= 1'b1;
          if (pick_valid) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (take && g_eop) begin
            last_grant  <= grant_idx;
            grant_valid <= 1'b0;
            state       <= ARB_IDLE;
          end
        end
      endcase

      if (take) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_sop   <= g_sop;
        out_eop   <= g_eop;
        out_empty <= g_eop ? g_empty : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        out_data  <= '0;
        out_empty <= '0;
      end
    end
  end

`ifdef AES_TX_ARB_STATS_EN
  logic [31:0] cnt [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else if (take && g_eop) begin
      cnt[grant_idx] <= cnt[grant_idx] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_count[i*32 +: 32] = cnt[i];
  end
`endif

endmodule
